// File: rtl/sram_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_stage
// Purpose  : ARM pipeline MEM stage; each 32-bit load/store is split into two
//            16-bit wait-stated SRAM accesses while ready freezes the pipeline.
//            Optional one-entry read cache enabled by macro MEM_RD_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_mem_stage #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        mem_result,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0]  c_CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] c_BASE     = 32'(BASE_ADDR);

    state_t               r_state_q,      w_state_d;
    logic [3:0]           r_cnt_q,        w_cnt_d;
    logic                 r_wr_q,         w_wr_d;
    logic [SRAM_AW-2:0]   r_word_q,       w_word_d;
    logic [31:0]          r_wdata_q,      w_wdata_d;
    logic [15:0]          r_rd_lo_q,      w_rd_lo_d;
    logic [15:0]          r_rd_hi_q,      w_rd_hi_d;
    logic [31:0]          r_mem_result_q, w_mem_result_d;
    logic [SRAM_AW-1:0]   r_sram_addr_q,  w_sram_addr_d;
    logic [15:0]          r_dq_out_q,     w_dq_out_d;
    logic                 r_dq_oe_q,      w_dq_oe_d;
    logic                 r_we_n_q,       w_we_n_d;

    logic [31:0] w_offset;
    logic        w_req;
    logic        w_busy_d;
    logic        w_cache_hit;
    logic [31:0] w_cache_data;
    logic        w_unused_bits;

    assign w_offset      = ALU_result - c_BASE;
    assign w_req         = MEM_R_EN | MEM_W_EN;
    // Address bits above the SRAM range wrap away by design.
    assign w_unused_bits = ^{w_offset[1:0], w_offset[31:SRAM_AW+1]};

    // Next-state logic; SRAM pins are registered from the next state so they
    // line up exactly with the state they belong to, without glitches.
    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_wr_d         = r_wr_q;
        w_word_d       = r_word_q;
        w_wdata_d      = r_wdata_q;
        w_rd_lo_d      = r_rd_lo_q;
        w_rd_hi_d      = r_rd_hi_q;
        w_mem_result_d = r_mem_result_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_req && !w_cache_hit) begin
                    w_state_d = ST_LOW;
                    w_cnt_d   = 4'd0;
                    w_wr_d    = MEM_W_EN;
                    w_word_d  = w_offset[SRAM_AW:2];
                    w_wdata_d = Val_Rm;
                end
            end
            ST_LOW: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    if (!r_wr_q) begin
                        w_rd_lo_d = SRAM_DQ_in;
                    end
                    w_state_d = ST_HIGH;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
            ST_HIGH: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    if (!r_wr_q) begin
                        w_rd_hi_d = SRAM_DQ_in;
                    end
                    w_state_d = ST_DONE;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // The pipeline advances on this edge, so never restart here.
                w_state_d      = ST_IDLE;
                w_mem_result_d = {r_rd_hi_q, r_rd_lo_q};
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d      = (w_state_d == ST_LOW) || (w_state_d == ST_HIGH);
        w_sram_addr_d = r_sram_addr_q;
        w_dq_out_d    = r_dq_out_q;
        if (w_state_d == ST_LOW) begin
            w_sram_addr_d = {w_word_d, 1'b0};
        end else if (w_state_d == ST_HIGH) begin
            w_sram_addr_d = {w_word_d, 1'b1};
        end
        if (w_busy_d && w_wr_d) begin
            w_dq_out_d = (w_state_d == ST_HIGH) ? w_wdata_d[31:16] : w_wdata_d[15:0];
        end
        w_dq_oe_d = w_busy_d && w_wr_d;
        // Last cycle of each half keeps WE_N high so data holds past the strobe.
        w_we_n_d  = !(w_busy_d && w_wr_d && (w_cnt_d != c_CNT_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= 4'd0;
            r_wr_q         <= 1'b0;
            r_word_q       <= '0;
            r_wdata_q      <= 32'd0;
            r_rd_lo_q      <= 16'd0;
            r_rd_hi_q      <= 16'd0;
            r_mem_result_q <= 32'd0;
            r_sram_addr_q  <= '0;
            r_dq_out_q     <= 16'd0;
            r_dq_oe_q      <= 1'b0;
            r_we_n_q       <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_wr_q         <= w_wr_d;
            r_word_q       <= w_word_d;
            r_wdata_q      <= w_wdata_d;
            r_rd_lo_q      <= w_rd_lo_d;
            r_rd_hi_q      <= w_rd_hi_d;
            r_mem_result_q <= w_mem_result_d;
            r_sram_addr_q  <= w_sram_addr_d;
            r_dq_out_q     <= w_dq_out_d;
            r_dq_oe_q      <= w_dq_oe_d;
            r_we_n_q       <= w_we_n_d;
        end
    end

    assign SRAM_ADDR   = r_sram_addr_q;
    assign SRAM_DQ_out = r_dq_out_q;
    assign SRAM_DQ_oe  = r_dq_oe_q;
    assign SRAM_WE_N   = r_we_n_q;

    // Ready is combinational in IDLE so the freeze takes effect in the request cycle.
    always_comb begin
        ready      = 1'b0;
        mem_result = r_mem_result_q;
        case (r_state_q)
            ST_IDLE: ready = !w_req || w_cache_hit;
            ST_DONE: begin
                ready      = 1'b1;
                mem_result = {r_rd_hi_q, r_rd_lo_q};
            end
            default: ready = 1'b0;
        endcase
        if (w_cache_hit) begin
            mem_result = w_cache_data;
        end
    end

`ifdef MEM_RD_CACHE_EN
    logic        r_c_valid_q,   w_c_valid_d;
    logic [29:0] r_c_tag_q,     w_c_tag_d;
    logic [31:0] r_c_data_q,    w_c_data_d;
    logic [29:0] r_req_tag_q,   w_req_tag_d;

    // Tag uses the full word address so wrapped aliases never hit falsely.
    assign w_cache_hit  = (r_state_q == ST_IDLE) && MEM_R_EN && !MEM_W_EN &&
                          r_c_valid_q && (r_c_tag_q == w_offset[31:2]);
    assign w_cache_data = r_c_data_q;

    always_comb begin
        w_c_valid_d = r_c_valid_q;
        w_c_tag_d   = r_c_tag_q;
        w_c_data_d  = r_c_data_q;
        w_req_tag_d = r_req_tag_q;
        if ((r_state_q == ST_IDLE) && w_req) begin
            w_req_tag_d = w_offset[31:2];
        end
        if (r_state_q == ST_DONE) begin
            if (!r_wr_q) begin
                w_c_valid_d = 1'b1;
                w_c_tag_d   = r_req_tag_q;
                w_c_data_d  = {r_rd_hi_q, r_rd_lo_q};
            end else if (r_c_valid_q && (r_c_tag_q == r_req_tag_q)) begin
                w_c_data_d = r_wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid_q <= 1'b0;
            r_c_tag_q   <= 30'd0;
            r_c_data_q  <= 32'd0;
            r_req_tag_q <= 30'd0;
        end else begin
            r_c_valid_q <= w_c_valid_d;
            r_c_tag_q   <= w_c_tag_d;
            r_c_data_q  <= w_c_data_d;
            r_req_tag_q <= w_req_tag_d;
        end
    end
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_data = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_mem_stage
// Purpose  : Self-checking bench for sram_mem_stage with a 16-bit SRAM model,
//            vector tables and write/read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_mem_stage;

    localparam int AW = 18;

`ifdef MEM_RD_CACHE_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 9;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_res;
        int          exp_lat;
        logic [31:0] exp_last_addr;
        int          idle;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   ALU_result;
    logic [31:0]   Val_Rm;
    logic [31:0]   mem_result;
    logic          ready;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_out;
    logic [15:0]   SRAM_DQ_in;
    logic          SRAM_DQ_oe;
    logic          SRAM_WE_N;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] wr_exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [15:0] sram_mem [0:(1<<AW)-1];

    sram_mem_stage #(
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(4),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .Val_Rm     (Val_Rm),
        .mem_result (mem_result),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) begin
            sram_mem[SRAM_ADDR] <= SRAM_DQ_out;
        end
    end
    assign SRAM_DQ_in = sram_mem[SRAM_ADDR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [31:0] a, input logic half);
        logic [31:0] off;
        off = a - 32'd1024;
        return {off[AW:2], half};
    endfunction

    // Write monitor: each WE_N low pulse must match the next expected half-write.
    logic prev_we_n = 1'b1;
    int   low_cnt   = 0;
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst) begin
            prev_we_n = 1'b1;
        end else begin
            if (!SRAM_WE_N && prev_we_n) begin
                check("wr_oe", {31'd0, SRAM_DQ_oe}, 32'd1);
                if (wr_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%05h data 0x%04h, required no write",
                             SRAM_ADDR, SRAM_DQ_out);
                end else begin
                    e = wr_exp_q.pop_front();
                    check("wr_addr", 32'(SRAM_ADDR), 32'(e[33:16]));
                    check("wr_data", 32'(SRAM_DQ_out), 32'(e[15:0]));
                end
                low_cnt = 1;
            end else if (!SRAM_WE_N) begin
                low_cnt++;
            end else if (!prev_we_n) begin
                check("we_low_cycles", 32'(low_cnt), 32'd3);
            end
            prev_we_n = SRAM_WE_N;
        end
    end

    task automatic run_op(input vec_t v, input string name);
        int          lat;
        logic        got;
        logic [31:0] res;
        logic [31:0] e;
        if (v.wr) begin
            wr_exp_q.push_back({exp_addr(v.addr, 1'b0), v.wdata[15:0]});
            wr_exp_q.push_back({exp_addr(v.addr, 1'b1), v.wdata[31:16]});
        end else if (v.rd) begin
            rd_exp_q.push_back(v.exp_res);
        end
        @(posedge clk);
        #1;
        MEM_R_EN   = v.rd;
        MEM_W_EN   = v.wr;
        ALU_result = v.addr;
        Val_Rm     = v.wdata;
        lat = 0;
        got = 1'b0;
        res = 32'd0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                res = mem_result;
            end else begin
                lat++;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        if (v.rd && !v.wr && rd_exp_q.size() > 0) begin
            e = rd_exp_q.pop_front();
            check({name, "_result"}, res, e);
        end
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        for (int i = 0; i < v.idle; i++) begin
            @(negedge clk);
            check({name, "_idle_ready"}, {31'd0, ready}, 32'd1);
            check({name, "_idle_we_n"}, {31'd0, SRAM_WE_N}, 32'd1);
            check({name, "_idle_addr"}, 32'(SRAM_ADDR), v.exp_last_addr);
        end
    endtask

    vec_t tbl1[6];
    vec_t tbl2[4];

    initial begin
        tbl1[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0,        9, 32'd5,       2};
        tbl1[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, 9, 32'd5,       10};
        tbl1[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'h0,        9, 32'd3,       2};
        tbl1[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 9, 32'd3,       2};
        tbl1[4] = '{1'b0, 1'b1, 32'd1020, 32'h0000CAFE, 32'h0,        9, 32'h3FFFF,   2};
        tbl1[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h0000CAFE, 9, 32'h3FFFF,   2};

        tbl2[0] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, 9,       32'd5, 2};
        tbl2[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, HIT_LAT, 32'd5, 2};
        tbl2[2] = '{1'b0, 1'b1, 32'd1032, 32'h00000001, 32'h0,        9,       32'd5, 2};
        tbl2[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h00000001, HIT_LAT, 32'd5, 2};

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd0;
        Val_Rm     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
        check("rst_mem_result", mem_result, 32'd0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_dq_out", 32'(SRAM_DQ_out), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl1[i], $sformatf("t1_%0d", i));
        end

        // Reset in the HIGH phase of a read: abandoned, no completion pulse.
        @(posedge clk);
        #1;
        MEM_R_EN   = 1'b1;
        ALU_result = 32'd1100;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("midrst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_mem_result", mem_result, 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            run_op(tbl2[i], $sformatf("t2_%0d", i));
        end

        repeat (3) @(negedge clk);
        check("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- MEM stage of the ARM pipeline, directly downstream of the EXE stage.
- Takes the EXE ALU result as the byte address and Val_Rm as store data.
- Performs each 32-bit load/store as two 16-bit accesses to an external SRAM, using a wait-state FSM.
- Drives a ready signal; while ready is low, the whole pipeline is frozen.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 4: cycles each 16-bit half-access is held; legal values 2..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_R_EN  input  1  load request, from EXE/MEM register.
- MEM_W_EN  input  1  store request, from EXE/MEM register.
- ALU_result  input  32  byte address computed by EXE.
- Val_Rm  input  32  store data.
- mem_result  output  32  load data; valid when ready=1 and MEM_R_EN=1.
- ready  output  1  0 = freeze pipeline.
- SRAM_ADDR  output  SRAM_AW  SRAM half-word address.
- SRAM_DQ_out  output  16  write data to SRAM.
- SRAM_DQ_in  input  16  read data from SRAM.
- SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the pad.
- SRAM_WE_N  output  1  active-low write enable.

Behaviour:
- Address mapping:
  - word = (ALU_result - BASE_ADDR) >> 2, 32-bit subtract.
  - SRAM_ADDR = {word[SRAM_AW-2:0], half}, with half=0 for bits 15:0 and half=1 for bits 31:16.
  - No range check; out-of-range addresses wrap modulo 2^SRAM_AW.
- FSM states: IDLE, LOW, HIGH, DONE. A per-phase counter cnt counts 0..WAIT_CYCLES-1.
- IDLE:
  - ready = ~(MEM_R_EN | MEM_W_EN), combinational, so the freeze applies in the request cycle.
  - A request latches op, address and Val_Rm, then moves to LOW with cnt=0.
  - If MEM_R_EN and MEM_W_EN are both high, the write wins.
- LOW / HIGH:
  - ready=0.
  - SRAM_ADDR carries half 0 in LOW and half 1 in HIGH.
  - Writes: SRAM_DQ_oe=1. SRAM_DQ_out = Val_Rm[15:0] in LOW, Val_Rm[31:16] in HIGH. SRAM_WE_N=0 for cnt < WAIT_CYCLES-1; the last cycle is WE_N=1 for data hold.
  - Reads: SRAM_DQ_oe=0, WE_N=1. SRAM_DQ_in is captured at the edge ending the last cycle (cnt=WAIT_CYCLES-1) into rd_lo (LOW) or rd_hi (HIGH).
  - At cnt=WAIT_CYCLES-1, LOW moves to HIGH and HIGH moves to DONE.
- DONE:
  - ready=1 for exactly one cycle; mem_result = {rd_hi, rd_lo}.
  - Always returns to IDLE, even though the request inputs are still high (the pipeline advances on this edge).
  - A request is never restarted from DONE.
- Latency: with the request first seen in IDLE at cycle 0, ready is low for cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1.
- Idle outputs: SRAM_WE_N=1, SRAM_DQ_oe=0. SRAM_ADDR holds its last value.
- mem_result holds its last value outside DONE unless the cache feature supplies it.
- Reset, including mid-operation:
  - state=IDLE, cnt=0, rd_lo=rd_hi=0.
  - mem_result=0, SRAM_ADDR=0, SRAM_DQ_out=0.
  - SRAM_DQ_oe=0, SRAM_WE_N=1.
  - Any in-flight access is abandoned with no completion pulse.
- Requests with neither enable never touch the SRAM.

Optional Feature:
- Macro MEM_RD_CACHE_EN: a one-entry read cache holding {valid, word address, data}.
- Read hit in IDLE (valid and address match):
  - ready=1 in the same cycle.
  - mem_result = cached data, combinational.
  - No SRAM access and no FSM transition.
- Read miss: the entry is filled in DONE.
- Write to the cached address: the entry is updated with Val_Rm at DONE.
- Writes never allocate.
- Reset clears valid.
- Without the macro: every read uses the FSM; the cache logic is absent.

Test Plan (BASE_ADDR=1024, WAIT_CYCLES=4):
- Reset: assert rst with the FSM in HIGH -> next cycle ready=1 (no request), SRAM_WE_N=1, SRAM_DQ_oe=0, mem_result=0.
- Store: ALU_result=1032, Val_Rm=0xDEADBEEF, MEM_W_EN=1 -> ready low 9 cycles; SRAM_ADDR=4 with DQ 0xBEEF, then 5 with 0xDEAD; WE_N low 3 of 4 cycles per half; ready=1 on cycle 9.
- Load back: MEM_R_EN at 1032, SRAM model returning stored halves -> mem_result=0xDEADBEEF with ready=1 at cycle 9.
- Idle and simultaneous: no enables for 10 cycles -> ready=1, WE_N=1, SRAM_ADDR unchanged. Then R=W=1 at 1028 with 0x12345678 -> write performed to SRAM_ADDR 2/3.
- Wrap: ALU_result=1020 store 0x0000CAFE -> SRAM_ADDR=0x3FFFE, then 0x3FFFF.
- MEM_RD_CACHE_EN:
  - Re-read 1032 -> ready=1 in cycle 0, 0xDEADBEEF, no SRAM activity.
  - Store 0x1 to 1032, then read -> 0x1 from the cache.
